// File: rtl/mux_scan_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sequencer_pkg
//  Description : Shared types and widths for the 4:1 mux scan sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_scan_sequencer_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

endpackage : mux_scan_sequencer_pkg
`default_nettype wire

// File: rtl/mux_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sequencer_if
//  Description : Control, mux feedback and result signals of the scan
//                sequencer. The slave side is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface mux_scan_sequencer_if;
    import mux_scan_sequencer_pkg::*;

    logic              start;
    logic              continuous;
    logic [NUM_CH-1:0] ch_mask;
    logic              mux_o;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] sample;
    logic              valid;
    logic              busy;

    modport master (
        output start, continuous, ch_mask, mux_o,
        input  sel, sample, valid, busy
    );

    modport slave (
        input  start, continuous, ch_mask, mux_o,
        output sel, sample, valid, busy
    );

endinterface : mux_scan_sequencer_if
`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_next_ch
//  Description : Finds the next enabled channel. With i_from_start set it
//                returns the lowest set mask bit; otherwise the lowest set
//                bit strictly above i_cur (no wrap-around).
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_next_ch
    import mux_scan_sequencer_pkg::*;
(
    input  wire logic [NUM_CH-1:0] i_mask,
    input  wire logic [SEL_W-1:0]  i_cur,
    input  wire logic              i_from_start,
    output logic      [SEL_W-1:0]  o_next,
    output logic                   o_found
);

    // Descending scan so the lowest qualifying index is the one left standing
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_start || (i > int'(i_cur)))) begin
                o_next  = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule : mux_scan_next_ch
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_sequencer
//  Description : Steps the select lines of an external 4:1 mux through the
//                enabled channels in ascending order, captures mux_o for each
//                and presents the assembled word with a one-cycle valid.
//  Revision    : 1.0  initial release
// ============================================================================
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYC = 1
)(
    input  wire logic             clk,
    input  wire logic             rst,
    mux_scan_sequencer_if.slave   bus
);

    // Value of the wait counter on the final settle cycle of a channel
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(SETTLE_CYC - 1);

    scan_state_t       r_state,  w_state;
    logic [NUM_CH-1:0] r_mask,   w_mask;
    logic [NUM_CH-1:0] r_result, w_result;
    logic [SEL_W-1:0]  r_ch,     w_ch;
    logic [WAIT_W-1:0] r_wait,   w_wait;
    logic [SEL_W-1:0]  r_sel,    w_sel;
    logic [NUM_CH-1:0] r_sample, w_sample;
    logic              r_valid,  w_valid;
    logic              r_busy,   w_busy;

    logic [NUM_CH-1:0] w_srch_mask;
    logic              w_srch_from_start;
    logic [SEL_W-1:0]  w_srch_next;
    logic              w_srch_found;

    // Outside SETTLE the search looks at the live mask for the first channel;
    // inside SETTLE it walks the snapshot upward from the current channel.
    assign w_srch_mask       = (r_state == SETTLE) ? r_mask : bus.ch_mask;
    assign w_srch_from_start = (r_state != SETTLE);

    mux_scan_next_ch u_next_ch (
        .i_mask       (w_srch_mask),
        .i_cur        (r_ch),
        .i_from_start (w_srch_from_start),
        .o_next       (w_srch_next),
        .o_found      (w_srch_found)
    );

    // Next-state, counters, capture and registered-output values
    always_comb begin
        w_state  = r_state;
        w_mask   = r_mask;
        w_result = r_result;
        w_ch     = r_ch;
        w_wait   = r_wait;
        w_sel    = r_sel;
        w_sample = r_sample;
        w_valid  = 1'b0;
        w_busy   = r_busy;

        case (r_state)
            IDLE, DONE: begin
                // IDLE launches on start, DONE relaunches on continuous
                if ((r_state == IDLE) ? bus.start : bus.continuous) begin
                    w_mask   = bus.ch_mask;
                    w_result = '0;
                    w_busy   = 1'b1;
                    if (w_srch_found) begin
                        w_ch    = w_srch_next;
                        w_wait  = '0;
                        w_sel   = w_srch_next;
                        w_state = SETTLE;
                    end else begin
                        // Empty mask: report an all-zero word immediately
                        w_sample = '0;
                        w_valid  = 1'b1;
                        w_sel    = '0;
                        w_state  = DONE;
                    end
                end else begin
                    w_sel   = '0;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end
            end

            SETTLE: begin
                if (r_wait == c_wait_last) begin
                    w_result[r_ch] = bus.mux_o;
                    if (w_srch_found) begin
                        w_ch   = w_srch_next;
                        w_wait = '0;
                        w_sel  = w_srch_next;
                    end else begin
                        w_sample = w_result;
                        w_valid  = 1'b1;
                        w_sel    = '0;
                        w_state  = DONE;
                    end
                end else begin
                    w_wait = r_wait + 1'b1;
                end
            end

            default: begin
                w_sel   = '0;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mask   <= '0;
            r_result <= '0;
            r_ch     <= '0;
            r_wait   <= '0;
            r_sel    <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_mask   <= w_mask;
            r_result <= w_result;
            r_ch     <= w_ch;
            r_wait   <= w_wait;
            r_sel    <= w_sel;
            r_sample <= w_sample;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
        end
    end

    assign bus.sel    = r_sel;
    assign bus.sample = r_sample;
    assign bus.valid  = r_valid;
    assign bus.busy   = r_busy;

endmodule : mux_scan_sequencer
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_sequencer
//  Description : Drives two sequencers (settle 1 and settle 3) with the same
//                control stimulus, each reading its own 4:1 mux, and compares
//                every cycle against a per-scan schedule of expected outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan_sequencer;
    import mux_scan_sequencer_pkg::*;

    localparam int c_settle_a = 1;
    localparam int c_settle_b = 3;

    typedef struct packed {
        logic [1:0] sel;
        logic       valid;
        logic [3:0] res;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] mask = 4'h0;
    logic [3:0] d_a = 4'h0;
    logic [3:0] d_b = 4'h0;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected-output schedules, one per DUT
    ent_t       sched [2][16];
    int         len  [2];
    int         pos  [2];
    logic [3:0] held [2];
    bit         prev_done [2];

    mux_scan_sequencer_if bus_a ();
    mux_scan_sequencer_if bus_b ();

    assign bus_a.start      = start;
    assign bus_a.continuous = cont;
    assign bus_a.ch_mask    = mask;
    assign bus_a.mux_o      = d_a[bus_a.sel];
    assign bus_b.start      = start;
    assign bus_b.continuous = cont;
    assign bus_b.ch_mask    = mask;
    assign bus_b.mux_o      = d_b[bus_b.sel];

    mux_scan_sequencer #(.SETTLE_CYC(c_settle_a)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_scan_sequencer #(.SETTLE_CYC(c_settle_b)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference for DUT k across one rising edge; returns the
    // expected entry for the following cycle and whether the DUT is idle.
    task automatic model_edge(input int k, input logic [3:0] dk, output ent_t e, output bit idle);
        int  n;
        int  s_cyc;
        bit  acc;
        s_cyc = (k == 0) ? c_settle_a : c_settle_b;
        if (rst) begin
            len[k] = 0; pos[k] = 0; held[k] = 4'h0; prev_done[k] = 1'b0;
            e = '0; idle = 1'b1;
            return;
        end
        if (pos[k] == len[k]) begin
            acc = prev_done[k] ? cont : start;
            len[k] = 0; pos[k] = 0;
            if (acc) begin
                n = 0;
                for (int c = 0; c < 4; c++) begin
                    if (mask[c]) begin
                        for (int s = 0; s < s_cyc; s++) begin
                            sched[k][n] = '{sel: 2'(c), valid: 1'b0, res: 4'h0};
                            n++;
                        end
                    end
                end
                sched[k][n] = '{sel: 2'd0, valid: 1'b1, res: (mask & dk)};
                n++;
                len[k] = n;
            end
        end
        if (pos[k] < len[k]) begin
            e = sched[k][pos[k]];
            pos[k]++;
            idle = 1'b0;
        end else begin
            e = '0;
            idle = 1'b1;
        end
        prev_done[k] = !idle && e.valid;
        if (e.valid) held[k] = e.res;
    endtask

    // One clock cycle: apply inputs, step the reference, compare both DUTs.
    // Mux data only changes while the corresponding DUT is not mid-scan.
    task automatic step(input bit r, input bit s, input bit c, input logic [3:0] m,
                        input logic [3:0] na, input logic [3:0] nb);
        ent_t ea, eb;
        bit   ia, ib;
        @(negedge clk);
        rst = r; start = s; cont = c; mask = m;
        if (pos[0] == len[0]) d_a = na;
        if (pos[1] == len[1]) d_b = nb;
        @(posedge clk);
        model_edge(0, d_a, ea, ia);
        model_edge(1, d_b, eb, ib);
        #1;
        check_eq("a.sel",    32'(bus_a.sel),    32'(ea.sel));
        check_eq("a.valid",  32'(bus_a.valid),  32'(ea.valid));
        check_eq("a.busy",   32'(bus_a.busy),   32'(!ia));
        check_eq("a.sample", 32'(bus_a.sample), 32'(held[0]));
        check_eq("b.sel",    32'(bus_b.sel),    32'(eb.sel));
        check_eq("b.valid",  32'(bus_b.valid),  32'(eb.valid));
        check_eq("b.busy",   32'(bus_b.busy),   32'(!ib));
        check_eq("b.sample", 32'(bus_b.sample), 32'(held[1]));
    endtask

    initial begin
        len[0] = 0; len[1] = 0; pos[0] = 0; pos[1] = 0;
        held[0] = 4'h0; held[1] = 4'h0;
        prev_done[0] = 1'b0; prev_done[1] = 1'b0;

        // Reset state
        step(1, 0, 0, 4'h0, 4'h0, 4'h0);
        step(1, 1, 1, 4'hF, 4'h0, 4'h0);

        // Full mask, d = 1101
        step(0, 1, 0, 4'hF, 4'b1101, 4'b1101);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4'hF, 4'b1101, 4'b1101);

        // Sparse mask 1010 with d1 = 1, d3 = 0
        step(0, 1, 0, 4'b1010, 4'b0010, 4'b0010);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 4'b1010, 4'b0010, 4'b0010);

        // Single channel 0
        step(0, 1, 0, 4'b0001, 4'b0001, 4'b0001);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 4'b0001, 4'b0001, 4'b0001);

        // Continuous scanning, fresh mux data per scan, stray start pulses
        step(0, 1, 1, 4'hF, 4'($urandom), 4'($urandom));
        for (int i = 0; i < 40; i++)
            step(0, 1'($urandom_range(0, 1)), 1, 4'hF, 4'($urandom), 4'($urandom));
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4'hF, 4'h0, 4'h0);

        // Reset in the middle of a scan (first DUT is on channel 2)
        step(0, 1, 0, 4'hF, 4'b0110, 4'b0110);
        step(0, 0, 0, 4'hF, 4'b0110, 4'b0110);
        step(0, 0, 0, 4'hF, 4'b0110, 4'b0110);
        step(1, 0, 0, 4'hF, 4'b0110, 4'b0110);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4'hF, 4'b0110, 4'b0110);

        // Empty mask, one-shot and continuous
        step(0, 1, 0, 4'h0, 4'hF, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF, 4'hF);
        step(0, 1, 1, 4'h0, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'h0, 4'hF, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF, 4'hF);

        // Mask changes during a full-mask scan must not alter it
        step(0, 1, 0, 4'hF, 4'b1001, 4'b1001);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 4'($urandom), 4'b1001, 4'b1001);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mux_scan_sequencer
`default_nettype wire
